// File: rtl/bfloat_pkg.sv
// Shared bfloat16 types and constants for the streaming accumulator slice.
package bfloat_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
  localparam logic [15:0] BF16_ZERO    = 16'h0000;

  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_t;

endpackage

// File: rtl/bf16_mag_add.sv
// Combinational bfloat16 magnitude add. Operand a is the running sum and
// supplies the result sign; b is the incoming sample. Zero/denormal operands
// pass the other operand through; an infinite running sum is held.
module bf16_mag_add
  import bfloat_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        ovf
);

  bf16_t       x, y, hi, lo;
  logic [7:0]  d;
  logic [11:0] mh, ml, ms;
  logic [8:0]  e;
  logic [8:0]  mr;
  logic        inc;

  // Align, add magnitudes, renormalise on carry, round to nearest even, saturate.
  always_comb begin
    x   = a;
    y   = b;
    hi  = x;
    lo  = y;
    d   = 8'd0;
    mh  = 12'd0;
    ml  = 12'd0;
    ms  = 12'd0;
    e   = 9'd0;
    mr  = 9'd0;
    inc = 1'b0;
    sum = a;
    ovf = 1'b0;
    if (y.exp == 8'd0) begin
      sum = a;
    end else if (x.exp == 8'd0) begin
      sum = b;
    end else if (x.exp == BF16_EXP_MAX) begin
      sum = {x.sign, BF16_EXP_MAX, 7'h00};
    end else begin
      if (x.exp >= y.exp) begin
        hi = x;
        lo = y;
      end else begin
        hi = y;
        lo = x;
      end
      d  = hi.exp - lo.exp;
      mh = {2'b01, hi.man, 3'b000};
      ml = {2'b01, lo.man, 3'b000};
      ml = (d >= 8'd12) ? 12'd0 : (ml >> d);
      ms = mh + ml;
      e  = {1'b0, hi.exp};
      if (ms[11]) begin
        ms = ms >> 1;
        e  = e + 9'd1;
      end
      // g = bit3 (result lsb), r = bit2, s = bit1|bit0
      inc = ms[2] & (ms[3] | ms[1] | ms[0]);
      mr  = {1'b0, ms[10:3]} + {8'd0, inc};
      if (mr[8]) begin
        mr = mr >> 1;
        e  = e + 9'd1;
      end
      if (e >= {1'b0, BF16_EXP_MAX}) begin
        sum = {x.sign, BF16_EXP_MAX, 7'h00};
        ovf = 1'b1;
      end else begin
        sum = {x.sign, e[7:0], mr[6:0]};
      end
    end
  end

endmodule

// File: rtl/bfloat_stream_acc.sv
// Streaming bfloat16 accumulator: sums one burst of samples and presents a
// single held result with beat count, overflow and truncation flags.
module bfloat_stream_acc
  import bfloat_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  localparam logic [CNT_W:0] MAX_L    = MAX_LEN[CNT_W:0];
  localparam bit             ONE_BEAT = (MAX_LEN == 1);

  acc_state_t       state, state_nxt;
  logic [15:0]      acc;
  logic [CNT_W-1:0] count;
  logic             ovf, trunc;
  logic [15:0]      add_sum;
  logic             add_ovf;
  logic [CNT_W:0]   cnt_inc;
  logic             hit_max, accept;

  bf16_mag_add u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign accept  = in_valid && in_ready;
  assign cnt_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign hit_max = (cnt_inc == MAX_L);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: close the burst on in_last or on reaching the beat limit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (in_last || ONE_BEAT) ? DONE : ACC;
      ACC:  if (accept && (in_last || hit_max)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready held low while reset is asserted
  always_comb begin
    in_ready  = rst_n && (state != DONE);
    out_valid = (state == DONE);
  end

  // Running sum, beat count and sticky flags; frozen while the result is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= BF16_ZERO;
      count <= '0;
      ovf   <= 1'b0;
      trunc <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        // denormal/zero first beat loads a clean zero so the sign comes from the first real sample
        acc   <= (in_data[14:7] == 8'd0) ? BF16_ZERO : in_data;
        count <= {{(CNT_W-1){1'b0}}, 1'b1};
        ovf   <= 1'b0;
        trunc <= ONE_BEAT && !in_last;
      end else begin
        acc   <= add_sum;
        count <= cnt_inc[CNT_W-1:0];
        ovf   <= ovf | add_ovf;
        trunc <= hit_max && !in_last;
      end
    end
  end

  assign out_data  = acc;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign out_trunc = trunc;

endmodule

// File: tb/tb_bfloat_stream_acc.sv
// Directed bench for the streaming bfloat16 accumulator.
module tb_bfloat_stream_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready, in_ready, out_valid, out_ovf, out_trunc;
  logic [15:0] in_data, out_data;
  logic [7:0]  out_count;

  logic        t_in_valid, t_in_last, t_out_ready, t_in_ready, t_out_valid, t_out_ovf, t_out_trunc;
  logic [15:0] t_in_data, t_out_data;
  logic [7:0]  t_out_count;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  bfloat_stream_acc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf), .out_trunc(out_trunc)
  );

  bfloat_stream_acc #(.CNT_W(8), .MAX_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data), .in_last(t_in_last),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
    .out_count(t_out_count), .out_ovf(t_out_ovf), .out_trunc(t_out_trunc)
  );

  task automatic beat(input logic [15:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'hDEAD;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0; out_ready = 1'b1;
    t_in_valid = 1'b0; t_in_last = 1'b0; t_in_data = 16'h0; t_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if ({out_data, out_count, out_ovf, out_trunc} !== 26'd0)
      $display("FAIL reset_outputs got %h/%0d/%b/%b want 0", out_data, out_count, out_ovf, out_trunc); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_single;
    beat(16'h3F80, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else pass_cnt++;
    total++; if (out_data !== 16'h3F80) $display("FAIL single_data got %h want 3f80", out_data); else pass_cnt++;
    total++; if (out_count !== 8'd1) $display("FAIL single_count got %0d want 1", out_count); else pass_cnt++;
    total++; if ({out_ovf, out_trunc} !== 2'b00) $display("FAIL single_flags got %b%b want 00", out_ovf, out_trunc); else pass_cnt++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL single_drained got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_sum;
    for (int i = 0; i < 4; i++) beat(16'h3F80, i == 3);
    @(negedge clk);
    total++; if (out_data !== 16'h4080) $display("FAIL sum4_data got %h want 4080", out_data); else pass_cnt++;
    total++; if (out_count !== 8'd4) $display("FAIL sum4_count got %0d want 4", out_count); else pass_cnt++;
    beat(16'h3F80, 1'b0); beat(16'h4000, 1'b1);
    @(negedge clk);
    total++; if (out_data !== 16'h4040) $display("FAIL sum_1p2 got %h want 4040", out_data); else pass_cnt++;
  endtask

  task automatic test_round;
    logic [15:0] a_v [4] = '{16'h3F80, 16'h3F81, 16'h3F80, 16'h3F80};
    logic [15:0] b_v [4] = '{16'h3B80, 16'h3B80, 16'h3C00, 16'h0000};
    logic [15:0] e_v [4] = '{16'h3F80, 16'h3F82, 16'h3F81, 16'h3F80};
    for (int i = 0; i < 4; i++) begin
      beat(a_v[i], 1'b0); beat(b_v[i], 1'b1);
      @(negedge clk);
      total++; if (out_data !== e_v[i]) $display("FAIL round_%0d got %h want %h", i, out_data, e_v[i]); else pass_cnt++;
    end
    // zero first beat then a negative sample: sign comes from the first non-zero sample
    beat(16'h0000, 1'b0); beat(16'hBF80, 1'b0); beat(16'h3F80, 1'b1);
    @(negedge clk);
    total++; if (out_data !== 16'hC000) $display("FAIL sign_latch got %h want c000", out_data); else pass_cnt++;
  endtask

  task automatic test_overflow;
    beat(16'h7F00, 1'b0); beat(16'h7F00, 1'b1);
    @(negedge clk);
    total++; if (out_data !== 16'h7F80) $display("FAIL ovf_data got %h want 7f80", out_data); else pass_cnt++;
    total++; if (out_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", out_ovf); else pass_cnt++;
    beat(16'h7F00, 1'b0); beat(16'h7F00, 1'b0); beat(16'h3F80, 1'b1);
    @(negedge clk);
    total++; if ({out_data, out_ovf, out_count} !== {16'h7F80, 1'b1, 8'd3})
      $display("FAIL ovf_sticky got %h/%b/%0d want 7f80/1/3", out_data, out_ovf, out_count); else pass_cnt++;
    beat(16'h3F80, 1'b1);
    @(negedge clk);
    total++; if (out_ovf !== 1'b0) $display("FAIL ovf_cleared got %b want 0", out_ovf); else pass_cnt++;
  endtask

  task automatic test_trunc;
    int acc_beats = 0;
    int cyc = 0;
    t_out_ready = 1'b0;
    @(negedge clk);
    t_in_valid = 1'b1; t_in_data = 16'h3F80; t_in_last = 1'b0;
    while (acc_beats < 3 && cyc < 20) begin
      @(posedge clk);
      if (t_in_valid && t_in_ready) acc_beats++;
      cyc++;
    end
    @(negedge clk);
    total++; if (t_out_valid !== 1'b1) $display("FAIL trunc_valid got %b want 1", t_out_valid); else pass_cnt++;
    total++; if ({t_out_data, t_out_count} !== {16'h4040, 8'd3})
      $display("FAIL trunc_result got %h/%0d want 4040/3", t_out_data, t_out_count); else pass_cnt++;
    total++; if ({t_out_trunc, t_in_ready} !== 2'b10)
      $display("FAIL trunc_flag got trunc=%b rdy=%b want 1/0", t_out_trunc, t_in_ready); else pass_cnt++;
    t_out_ready = 1'b1;
    @(posedge clk);
    // beats 4 and 5; the 5th carries in_last
    @(negedge clk);
    @(negedge clk); t_in_last = 1'b1;
    @(negedge clk); t_in_valid = 1'b0; t_in_last = 1'b0;
    total++; if ({t_out_valid, t_out_data, t_out_count, t_out_trunc} !== {1'b1, 16'h4000, 8'd2, 1'b0})
      $display("FAIL trunc_fresh got %b/%h/%0d/%b want 1/4000/2/0", t_out_valid, t_out_data, t_out_count, t_out_trunc);
    else pass_cnt++;
    @(negedge clk);
    t_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    beat(16'h3F80, 1'b0); beat(16'h4000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1;
      total++; if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 16'h4040, 8'd2})
        $display("FAIL hold_%0d got v=%b rdy=%b %h/%0d want 1/0/4040/2", i, out_valid, in_ready, out_data, out_count);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL hold_release got %b want 0", out_valid); else pass_cnt++;
    beat(16'h3F80, 1'b1);
    @(negedge clk);
    total++; if ({out_data, out_count} !== {16'h3F80, 8'd1})
      $display("FAIL after_hold got %h/%0d want 3f80/1", out_data, out_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    beat(16'h7F00, 1'b0); beat(16'h7F00, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out_valid, in_ready, out_data, out_count, out_ovf, out_trunc} !== 28'd0)
      $display("FAIL mid_reset got v=%b rdy=%b %h/%0d/%b/%b want all 0", out_valid, in_ready, out_data, out_count, out_ovf, out_trunc);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    beat(16'h3F80, 1'b1);
    @(negedge clk);
    total++; if ({out_valid, out_data, out_count, out_ovf} !== {1'b1, 16'h3F80, 8'd1, 1'b0})
      $display("FAIL post_reset got %b/%h/%0d/%b want 1/3f80/1/0", out_valid, out_data, out_count, out_ovf);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_sum;
    test_round;
    test_overflow;
    test_trunc;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
